// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong voice scheduler.
package ks_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LEN_W    = 10;
    localparam int unsigned MIN_LEN  = 2;
    localparam int unsigned INIT_PAD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StTick,
        StSettle,
        StMix,
        StAlloc,
        StKill,
        StPluck,
        StInit
    } sched_state_t;

endpackage

// File: rtl/ks_voice_alloc.sv
// Voice allocator: lowest-index free-voice encoder plus the round-robin steal pointer.
module ks_voice_alloc #(
    parameter int unsigned NumVoices = 4,
    parameter int unsigned IdxW      = $clog2(NumVoices)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumVoices-1:0] used_i,
    input  logic                 advance_i,
    output logic                 free_o,
    output logic [IdxW-1:0]      free_idx_o,
    output logic [IdxW-1:0]      steal_ptr_o
);

    logic [IdxW-1:0] steal_ptr_q, steal_ptr_d;

    assign free_o = ~&used_i;

    always_comb begin
        free_idx_o = '0;
        for (int i = NumVoices - 1; i >= 0; i--) begin
            if (!used_i[i]) begin
                free_idx_o = IdxW'(i);
            end
        end
    end

    // Power-of-two voice count lets the pointer wrap naturally.
    assign steal_ptr_d = advance_i ? steal_ptr_q + IdxW'(1) : steal_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            steal_ptr_q <= '0;
        end else begin
            steal_ptr_q <= steal_ptr_d;
        end
    end

    assign steal_ptr_o = steal_ptr_q;

endmodule

// File: rtl/ks_voice_scheduler.sv
// Note/tick scheduler and mixer for a bank of Karplus-Strong voices.
// Optional KS_SCHED_MUTE_EN adds a per-voice mute input that removes voices from the mix.
module ks_voice_scheduler
    import ks_pkg::*;
#(
    parameter int unsigned NumVoices = 4,
    parameter int unsigned LenW      = LEN_W,
    parameter int unsigned SampleW   = SAMPLE_W,
    parameter int unsigned SettleCyc = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         note_valid_i,
    output logic                         note_ready_o,
    input  logic [LenW-1:0]              note_len_i,
    input  logic                         sample_tick_i,
    output logic [NumVoices-1:0]         voice_pluck_o,
    output logic [NumVoices-1:0]         voice_data_over_o,
    output logic [NumVoices*LenW-1:0]    voice_len_o,
    input  logic [NumVoices*SampleW-1:0] voice_sample_i,
`ifdef KS_SCHED_MUTE_EN
    input  logic [NumVoices-1:0]         voice_mute_i,
`endif
    output logic [SampleW-1:0]           mix_out_o,
    output logic                         mix_valid_o,
    output logic                         overrun_o
);

    localparam int unsigned IdxW = $clog2(NumVoices);
    localparam int unsigned CntW = LenW + 1;
    localparam int unsigned SumW = SampleW + IdxW;

    sched_state_t state_q, state_d;

    logic [NumVoices-1:0]           used_q, used_d;
    logic [NumVoices-1:0]           live_q, live_d;
    logic                           tick_pend_q, tick_pend_d;
    logic                           overrun_q, overrun_d;
    logic [IdxW-1:0]                target_q, target_d;
    logic                           steal_q, steal_d;
    logic [LenW-1:0]                len_q, len_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic [NumVoices-1:0][LenW-1:0] voice_len_q, voice_len_d;
    logic [NumVoices-1:0]           pluck_q, pluck_d;
    logic [NumVoices-1:0]           dover_q, dover_d;
    logic [SampleW-1:0]             mix_out_q, mix_out_d;
    logic                           mix_valid_q, mix_valid_d;

    logic                 free_any;
    logic [IdxW-1:0]      free_idx;
    logic [IdxW-1:0]      steal_ptr;
    logic [IdxW-1:0]      alloc_tgt;
    logic                 tick_any;
    logic                 xfer;
    logic [LenW-1:0]      len_clamped;
    logic [NumVoices-1:0] mix_mask;
    logic [SumW-1:0]      mix_sum;

    assign tick_any     = tick_pend_q | sample_tick_i;
    assign note_ready_o = (state_q == StIdle) && !tick_any;
    assign xfer         = note_valid_i && note_ready_o;
    assign alloc_tgt    = free_any ? free_idx : steal_ptr;
    assign len_clamped  = (note_len_i < LenW'(MIN_LEN)) ? LenW'(MIN_LEN) : note_len_i;

    ks_voice_alloc #(
        .NumVoices (NumVoices),
        .IdxW      (IdxW)
    ) u_alloc (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .used_i      (used_q),
        .advance_i   (xfer && !free_any),
        .free_o      (free_any),
        .free_idx_o  (free_idx),
        .steal_ptr_o (steal_ptr)
    );

`ifdef KS_SCHED_MUTE_EN
    assign mix_mask = live_q & ~voice_mute_i;
`else
    assign mix_mask = live_q;
`endif

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NumVoices; i++) begin
            if (mix_mask[i]) begin
                mix_sum = mix_sum + SumW'(voice_sample_i[i*SampleW +: SampleW]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        live_d      = live_q;
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q;
        target_d    = target_q;
        steal_d     = steal_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        voice_len_d = voice_len_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;

        // Ticks outside IDLE are queued one deep; a second one is lost.
        if (state_q != StIdle && sample_tick_i) begin
            if (tick_pend_q) begin
                overrun_d = 1'b1;
            end else begin
                tick_pend_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (tick_any) begin
                    state_d     = StTick;
                    tick_pend_d = tick_pend_q & sample_tick_i;
                end else if (xfer) begin
                    // Length is written on accept so it leads pluck by a cycle.
                    state_d                = StAlloc;
                    target_d               = alloc_tgt;
                    steal_d                = !free_any;
                    len_d                  = len_clamped;
                    voice_len_d[alloc_tgt] = len_clamped;
                    live_d[alloc_tgt]      = 1'b0;
                end
            end
            StTick: begin
                state_d = StSettle;
                cnt_d   = CntW'(SettleCyc - 1);
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d     = StMix;
                    mix_out_d   = mix_sum[SumW-1:IdxW];
                    mix_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StMix: begin
                state_d = StIdle;
            end
            StAlloc: begin
                state_d = steal_q ? StKill : StPluck;
                cnt_d   = CntW'(1);
            end
            StKill: begin
                if (cnt_q == '0) begin
                    state_d = StPluck;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StPluck: begin
                used_d[target_q] = 1'b1;
                state_d          = StInit;
                cnt_d            = {1'b0, len_q} + CntW'(INIT_PAD - 1);
            end
            StInit: begin
                if (cnt_q == '0) begin
                    live_d[target_q] = 1'b1;
                    state_d          = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Voice strobes are registered off the next state so they align with it.
    always_comb begin
        pluck_d = '0;
        dover_d = '0;
        case (state_d)
            StTick: begin
                dover_d = live_q;
            end
            StKill: begin
                pluck_d[target_d] = 1'b1;
                dover_d[target_d] = 1'b1;
            end
            StPluck: begin
                pluck_d[target_d] = 1'b1;
            end
            default: begin
                pluck_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            used_q      <= '0;
            live_q      <= '0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            target_q    <= '0;
            steal_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            voice_len_q <= '0;
            pluck_q     <= '0;
            dover_q     <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            used_q      <= used_d;
            live_q      <= live_d;
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
            target_q    <= target_d;
            steal_q     <= steal_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            voice_len_q <= voice_len_d;
            pluck_q     <= pluck_d;
            dover_q     <= dover_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
        end
    end

    assign voice_pluck_o     = pluck_q;
    assign voice_data_over_o = dover_q;
    assign voice_len_o       = voice_len_q;
    assign mix_out_o         = mix_out_q;
    assign mix_valid_o       = mix_valid_q;
    assign overrun_o         = overrun_q;

endmodule
